// File: rtl/fetch_unit.sv
// Instruction fetch unit.
// Issues sequential word fetches to instruction memory and collects the
// in-order responses in a small instruction queue for decode. Taken branches
// flush the queue and restart fetch at the new address. Responses that were
// already in flight when a redirect happened are recognised only by counting
// them, and are then dropped.
`timescale 1ns/1ps

module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        id_valid,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    input  logic        id_ready
);

    // Pointer width for a power-of-two queue, and counter width that can
    // also hold the value DEPTH itself.
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_SUM = (CW + 1)'(DEPTH);

    // Architectural state and next-state values.
    logic [15:0]   fetchPc_q,     fetchPc_d;
    logic [CW-1:0] occupancy_q,   occupancy_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q,     discard_d;
    logic [PW-1:0] qHead_q,       qHead_d;
    logic [PW-1:0] qTail_q,       qTail_d;
    logic [PW-1:0] tagHead_q,     tagHead_d;
    logic [PW-1:0] tagTail_q,     tagTail_d;

    // Queue payload and the in-order tag FIFO holding request addresses.
    logic [15:0] qInstr_q  [DEPTH];
    logic [15:0] qPc_q     [DEPTH];
    logic [15:0] tagAddr_q [DEPTH];

    // Per-cycle events.
    logic        reqAccept;
    logic        respValid;
    logic        pushResp;
    logic        popHead;
    logic [CW:0] occPlusOut;

    // A response is only meaningful while something is outstanding; this also
    // keeps stray responses after a reset from corrupting the counters.
    assign respValid = imem_rvalid & (outstanding_q != '0);
    assign reqAccept = imem_req & imem_gnt;
    assign pushResp  = respValid & ~redirect & (discard_q == '0);
    assign popHead   = id_valid & id_ready & ~redirect;

    // Request only when every granted request is guaranteed a queue slot.
    always_comb begin
        occPlusOut = {1'b0, occupancy_q} + {1'b0, outstanding_q};
        imem_req   = Rst & ~redirect & (occPlusOut < DEPTH_SUM);
    end

    assign imem_addr = fetchPc_q;

    // Head of queue straight from the storage registers, zero when empty.
    always_comb begin
        id_valid = (occupancy_q != '0);
        id_instr = 16'h0000;
        id_pc    = 16'h0000;
        if (id_valid) begin
            id_instr = qInstr_q[qHead_q];
            id_pc    = qPc_q[qHead_q];
        end
    end

    // Fetch address: redirect wins, otherwise advance on every accepted request.
    always_comb begin
        fetchPc_d = fetchPc_q;
        if (redirect) begin
            fetchPc_d = redirect_pc;
        end else if (reqAccept) begin
            fetchPc_d = fetchPc_q + 16'd1;
        end
    end

    // Outstanding tracks every granted request until its response shows up,
    // whether that response is kept or dropped.
    always_comb begin
        outstanding_d = outstanding_q + CW'(reqAccept) - CW'(respValid);
    end

    // Discard count: on redirect every response still due becomes stale (the
    // one arriving this cycle is already dropped by the redirect itself).
    always_comb begin
        discard_d = discard_q;
        if (redirect) begin
            discard_d = outstanding_d;
        end else if (respValid && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end
    end

    // Queue bookkeeping: flush on redirect, otherwise push/pop with wrapping pointers.
    always_comb begin
        occupancy_d = occupancy_q;
        qHead_d     = qHead_q;
        qTail_d     = qTail_q;
        if (redirect) begin
            occupancy_d = '0;
            qHead_d     = '0;
            qTail_d     = '0;
        end else begin
            occupancy_d = occupancy_q + CW'(pushResp) - CW'(popHead);
            if (pushResp) begin
                qTail_d = qTail_q + PW'(1);
            end
            if (popHead) begin
                qHead_d = qHead_q + PW'(1);
            end
        end
    end

    // Tag FIFO pointers: one entry per grant, retired by any response. Not
    // flushed on redirect because stale responses still retire their tags.
    always_comb begin
        tagHead_d = tagHead_q;
        tagTail_d = tagTail_q;
        if (reqAccept) begin
            tagTail_d = tagTail_q + PW'(1);
        end
        if (respValid) begin
            tagHead_d = tagHead_q + PW'(1);
        end
    end

    // Control state with asynchronous reset; in-flight requests are forgotten.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fetchPc_q     <= RESET_PC;
            occupancy_q   <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            qHead_q       <= '0;
            qTail_q       <= '0;
            tagHead_q     <= '0;
            tagTail_q     <= '0;
        end else begin
            fetchPc_q     <= fetchPc_d;
            occupancy_q   <= occupancy_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            qHead_q       <= qHead_d;
            qTail_q       <= qTail_d;
            tagHead_q     <= tagHead_d;
            tagTail_q     <= tagTail_d;
        end
    end

    // Payload storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge Clk) begin
        if (pushResp) begin
            qInstr_q[qTail_q] <= imem_rdata;
            qPc_q[qTail_q]    <= tagAddr_q[tagHead_q];
        end
        if (reqAccept) begin
            tagAddr_q[tagTail_q] <= fetchPc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a small in-order memory model.
`timescale 1ns/1ps

module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        Clk         = 1'b0;
    logic        Rst         = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata  = 16'h0000;
    logic        redirect    = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        id_ready    = 1'b0;

    int          checks = 0;
    int          fails  = 0;
    logic [15:0] expPc  = 16'h0000;

    // Memory model state: granted requests waiting for their response.
    typedef struct {
        logic [15:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];
    int    cyc     = 0;
    bit    memHold = 1'b0;

    always #5 Clk = ~Clk;

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_ready    (id_ready)
    );

    // Memory contents as a function of the word address.
    function automatic logic [15:0] memWord(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Capture grants just before the rising edge.
    always @(negedge Clk) begin
        #4;
        if (Rst && imem_req && imem_gnt) begin
            pend.push_back('{imem_addr, cyc + 1});
        end
    end

    // Deliver responses in order one cycle after grant unless held.
    always @(posedge Clk) begin
        cyc = cyc + 1;
        #1;
        if (!memHold && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'h0000;
        end
    end

    // Stop grants, let all responses return and decode consume everything.
    task automatic drainQueue();
        int quiet = 0;
        imem_gnt = 1'b0;
        memHold  = 1'b0;
        id_ready = 1'b1;
        redirect = 1'b0;
        for (int c = 0; c < 60 && quiet < 3; c++) begin
            @(negedge Clk); #1;
            if (pend.size() == 0 && !imem_rvalid && !id_valid) quiet++;
            else quiet = 0;
        end
        checks++;
        if (quiet < 3) begin
            fails++;
            $display("[TB] FAIL drain_timeout: queue still busy after 60 cycles, required idle");
        end
    endtask

    task automatic test_reset();
        imem_gnt = 1'b1;
        id_ready = 1'b1;
        #1 Rst = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_req: got %b, required 0", imem_req);
        end
        checks++;
        if (id_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_valid: got %b, required 0", id_valid);
        end
        checks++;
        if (id_instr !== 16'h0000) begin
            fails++; $display("[TB] FAIL reset_instr: got %h, required 0000", id_instr);
        end
        checks++;
        if (id_pc !== 16'h0000) begin
            fails++; $display("[TB] FAIL reset_pc: got %h, required 0000", id_pc);
        end
        checks++;
        if (imem_addr !== RESET_PC) begin
            fails++; $display("[TB] FAIL reset_addr: got %h, required %h", imem_addr, RESET_PC);
        end
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            fails++; $display("[TB] FAIL first_req: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_streaming();
        expPc = RESET_PC;
        @(negedge Clk); #1;
        checks++;
        if (id_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL stream_early: id_valid=%b, required 0", id_valid);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk); #1;
            checks++;
            if (id_valid !== 1'b1 || id_pc !== expPc || id_instr !== memWord(expPc)) begin
                fails++;
                $display("[TB] FAIL stream_seq: valid=%b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                         id_valid, id_pc, id_instr, expPc, memWord(expPc));
            end
            expPc = expPc + 16'd1;
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            id_ready = 1'b0;
            #1;
            checks++;
            if (id_valid !== 1'b1 || id_pc !== expPc || id_instr !== memWord(expPc)) begin
                fails++;
                $display("[TB] FAIL bp_hold: valid=%b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                         id_valid, id_pc, id_instr, expPc, memWord(expPc));
            end
        end
        checks++;
        if (imem_req !== 1'b0) begin
            fails++; $display("[TB] FAIL bp_saturate: imem_req=%b, required 0", imem_req);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            id_ready = 1'b1;
            #1;
            if (i == 0) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    fails++; $display("[TB] FAIL bp_full_pop_req: imem_req=%b, required 0", imem_req);
                end
            end
            if (i == 1) begin
                checks++;
                if (imem_req !== 1'b1) begin
                    fails++; $display("[TB] FAIL bp_resume_req: imem_req=%b, required 1", imem_req);
                end
            end
            checks++;
            if (id_valid !== 1'b1 || id_pc !== expPc || id_instr !== memWord(expPc)) begin
                fails++;
                $display("[TB] FAIL bp_resume_seq: valid=%b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                         id_valid, id_pc, id_instr, expPc, memWord(expPc));
            end
            expPc = expPc + 16'd1;
        end
    endtask

    task automatic test_redirect_outstanding();
        int seen = 0;
        drainQueue();
        @(negedge Clk);
        memHold  = 1'b1;
        imem_gnt = 1'b1;
        repeat (2) @(negedge Clk);
        @(negedge Clk);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            fails++; $display("[TB] FAIL redir_noreq: imem_req=%b, required 0", imem_req);
        end
        @(negedge Clk);
        redirect = 1'b0;
        memHold  = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
            fails++; $display("[TB] FAIL redir_first_req: req=%b addr=%h, required req=1 addr=0040", imem_req, imem_addr);
        end
        @(negedge Clk); #1;
        checks++;
        if (imem_req !== 1'b0) begin
            fails++; $display("[TB] FAIL redir_limit: imem_req=%b with 4 outstanding, required 0", imem_req);
        end
        expPc = 16'h0040;
        for (int c = 0; c < 30 && seen < 4; c++) begin
            @(negedge Clk); #1;
            if (id_valid === 1'b1) begin
                checks++;
                if (id_pc !== expPc || id_instr !== memWord(expPc)) begin
                    fails++;
                    $display("[TB] FAIL redir_stream: pc=%h instr=%h, required pc=%h instr=%h",
                             id_pc, id_instr, expPc, memWord(expPc));
                end
                expPc = expPc + 16'd1;
                seen++;
            end
        end
        checks++;
        if (seen < 4) begin
            fails++; $display("[TB] FAIL redir_timeout: %0d instructions seen, required 4", seen);
        end
    endtask

    task automatic test_redirect_collision();
        int seen = 0;
        drainQueue();
        @(negedge Clk);
        imem_gnt    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        @(negedge Clk);
        redirect = 1'b0;
        expPc    = 16'h0020;
        for (int c = 0; c < 20 && seen < 6; c++) begin
            @(negedge Clk); #1;
            if (id_valid === 1'b1) begin
                checks++;
                if (id_pc !== expPc || id_instr !== memWord(expPc)) begin
                    fails++;
                    $display("[TB] FAIL coll_warmup: pc=%h instr=%h, required pc=%h instr=%h",
                             id_pc, id_instr, expPc, memWord(expPc));
                end
                expPc = expPc + 16'd1;
                seen++;
            end
        end
        checks++;
        if (seen < 6) begin
            fails++; $display("[TB] FAIL coll_warmup_timeout: %0d instructions seen, required 6", seen);
        end
        @(negedge Clk);
        redirect    = 1'b1;
        redirect_pc = 16'h0080;
        @(negedge Clk);
        redirect = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL coll_flush: id_valid=%b pc=%h, required 0", id_valid, id_pc);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin
            fails++; $display("[TB] FAIL coll_req: req=%b addr=%h, required req=1 addr=0080", imem_req, imem_addr);
        end
        expPc = 16'h0080;
        seen  = 0;
        for (int c = 0; c < 20 && seen < 4; c++) begin
            @(negedge Clk); #1;
            if (id_valid === 1'b1) begin
                checks++;
                if (id_pc !== expPc || id_instr !== memWord(expPc)) begin
                    fails++;
                    $display("[TB] FAIL coll_stream: pc=%h instr=%h, required pc=%h instr=%h",
                             id_pc, id_instr, expPc, memWord(expPc));
                end
                expPc = expPc + 16'd1;
                seen++;
            end
        end
        checks++;
        if (seen < 4) begin
            fails++; $display("[TB] FAIL coll_timeout: %0d instructions seen, required 4", seen);
        end
    endtask

    task automatic test_back_to_back();
        int seen = 0;
        @(negedge Clk);
        memHold = 1'b1;
        repeat (2) @(negedge Clk);
        @(negedge Clk);
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        memHold     = 1'b0;
        @(negedge Clk);
        redirect_pc = 16'h0200;
        @(negedge Clk);
        redirect = 1'b0;
        expPc    = 16'h0200;
        for (int c = 0; c < 30 && seen < 4; c++) begin
            @(negedge Clk); #1;
            if (id_valid === 1'b1) begin
                checks++;
                if (id_pc !== expPc || id_instr !== memWord(expPc)) begin
                    fails++;
                    $display("[TB] FAIL b2b_stream: pc=%h instr=%h, required pc=%h instr=%h",
                             id_pc, id_instr, expPc, memWord(expPc));
                end
                expPc = expPc + 16'd1;
                seen++;
            end
        end
        checks++;
        if (seen < 4) begin
            fails++; $display("[TB] FAIL b2b_timeout: %0d instructions seen, required 4", seen);
        end
    endtask

    task automatic test_wrap();
        int seen = 0;
        @(negedge Clk);
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        @(negedge Clk);
        redirect = 1'b0;
        expPc    = 16'hFFFE;
        for (int c = 0; c < 30 && seen < 4; c++) begin
            @(negedge Clk); #1;
            if (id_valid === 1'b1) begin
                checks++;
                if (id_pc !== expPc || id_instr !== memWord(expPc)) begin
                    fails++;
                    $display("[TB] FAIL wrap_stream: pc=%h instr=%h, required pc=%h instr=%h",
                             id_pc, id_instr, expPc, memWord(expPc));
                end
                expPc = expPc + 16'd1;
                seen++;
            end
        end
        checks++;
        if (seen < 4) begin
            fails++; $display("[TB] FAIL wrap_timeout: %0d instructions seen, required 4", seen);
        end
    endtask

    task automatic test_reset_midop();
        int seen = 0;
        drainQueue();
        @(negedge Clk);
        imem_gnt    = 1'b1;
        id_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0500;
        @(negedge Clk);
        redirect = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        memHold = 1'b1;
        @(negedge Clk);
        @(negedge Clk); #1;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 16'h0500 || imem_req !== 1'b0) begin
            fails++; $display("[TB] FAIL midop_setup: valid=%b pc=%h req=%b, required valid=1 pc=0500 req=0",
                              id_valid, id_pc, imem_req);
        end
        #1;
        Rst     = 1'b0;
        memHold = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b0 || imem_req !== 1'b0 || id_pc !== 16'h0000 || id_instr !== 16'h0000) begin
            fails++; $display("[TB] FAIL midop_async: valid=%b req=%b pc=%h instr=%h, required all 0",
                              id_valid, imem_req, id_pc, id_instr);
        end
        repeat (4) @(negedge Clk);
        #1;
        checks++;
        if (id_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL midop_late_resp: id_valid=%b during reset, required 0", id_valid);
        end
        @(negedge Clk);
        Rst      = 1'b1;
        id_ready = 1'b1;
        imem_gnt = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            fails++; $display("[TB] FAIL midop_restart: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
        expPc = RESET_PC;
        for (int c = 0; c < 20 && seen < 4; c++) begin
            @(negedge Clk); #1;
            if (id_valid === 1'b1) begin
                checks++;
                if (id_pc !== expPc || id_instr !== memWord(expPc)) begin
                    fails++;
                    $display("[TB] FAIL midop_stream: pc=%h instr=%h, required pc=%h instr=%h",
                             id_pc, id_instr, expPc, memWord(expPc));
                end
                expPc = expPc + 16'd1;
                seen++;
            end
        end
        checks++;
        if (seen < 4) begin
            fails++; $display("[TB] FAIL midop_timeout: %0d instructions seen, required 4", seen);
        end
    endtask

    // Overall time bound in case a scenario stalls.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_collision();
        test_back_to_back();
        test_wrap();
        test_reset_midop();
        repeat (2) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
